bias_add: RTL
=============

BIAS_ADD -- requirements
Module: bias_add

Interface
REQ-001 The block SHALL have parameter BIAS_DEPTH, default 4, giving the number of stored bias vectors.
REQ-002 The block SHALL use the lane width `QW and lane count `XW from params.svh. All lanes SHALL be two's-complement signed.
REQ-003 Ports (name, direction, width, meaning):
- clk, input, 1: single clock.
- rst, input, 1: reset; asynchronous, active-high.
- data_i, input, `QW x `XW: input vector; consumes the addbias branch of the residual split.
- valid_i, input, 1: input beat valid.
- ready_o, output, 1: block can accept a beat.
- data_o, output, `QW x `XW: biased output vector.
- valid_o, output, 1: output beat valid.
- ready_i, input, 1: downstream accepts the output beat.
- cfg_num_vec, input, $clog2(BIAS_DEPTH+1): number of bias vectors in one cycle of use.
- bias_wr_en, input, 1: bias table write strobe.
- bias_wr_addr, input, $clog2(BIAS_DEPTH): bias table write row.
- bias_wr_data, input, `QW x `XW: bias vector to write.
- vec_idx_o, output, $clog2(BIAS_DEPTH): bias row applied to the next accepted beat.

Function
REQ-004 An input beat SHALL be accepted on a clock edge when valid_i and ready_o are both 1.
REQ-005 An output beat SHALL complete on a clock edge when valid_o and ready_i are both 1.
REQ-006 ready_o SHALL equal (~valid_o | ready_i). This gives one output register with full throughput and no combinational path from valid_i to valid_o.
REQ-007 Latency SHALL be exactly one cycle: a beat accepted at edge N SHALL present valid_o=1 with its result after edge N.
REQ-008 When valid_o=1 and ready_i=0, data_o and valid_o SHALL hold stable.
REQ-009 When the output is held, ready_o=0 and no beat SHALL be accepted.
REQ-010 For lane k, data_o[k] SHALL be sat(data_i[k] + bias[vec_idx][k]).
- The sum SHALL be computed at `QW+1 bits.
- sat() SHALL clamp to the range [-2^(QW-1), 2^(QW-1)-1].
REQ-011 vec_idx SHALL increment by 1 on each accepted beat.
REQ-012 vec_idx SHALL wrap to 0 after the accepted beat where vec_idx >= eff_num-1.
- eff_num = max(cfg_num_vec, 1), further limited to BIAS_DEPTH.
- The >= compare keeps the counter inside range when cfg_num_vec shrinks mid-operation.
REQ-013 On bias_wr_en, bias_wr_data SHALL be written to row bias_wr_addr. Writes SHALL be accepted every cycle, independent of the data handshake.
REQ-014 When a write and an accepted beat hit the same row in the same cycle, the beat SHALL use the old row contents (read-before-write).
REQ-015 A bias write SHALL NOT stall, drop or reorder data beats.
REQ-016 vec_idx_o SHALL expose the current vec_idx register value.

Reset
REQ-017 While rst=1, the block SHALL force:
- valid_o=0;
- data_o all lanes = 0;
- vec_idx=0;
- all bias rows = 0.
REQ-018 When rst asserts while a beat is pending on the output, the pending beat SHALL be discarded without completing.
REQ-019 ready_o SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-020 The macro BIAS_ADD_RELU_EN SHALL select ReLU on the output.
- Defined: every lane result below 0 after saturation SHALL be output as 0.
- Undefined: the signed saturated result SHALL pass unchanged.
- Latency and handshake SHALL be identical in both builds.

Verification
Bench settings: QW=8, XW=4, BIAS_DEPTH=4.
REQ-021 Bias rows 0..2 written with {1,2,3,4}x(row+1), cfg_num_vec=3, 7 back-to-back beats of data_i={10,10,10,10}, ready_i=1 -> outputs {11,12,13,14}, {12,14,16,18}, {13,16,19,22}, then the sequence repeats; one output per cycle and vec_idx_o returns to 0 every third beat.
REQ-022 Bias row 0={100,-100,127,-128}, data_i={100,-100,1,-1} -> data_o={127,-128,127,-128}. With BIAS_ADD_RELU_EN defined -> data_o={127,0,127,0}.
REQ-023 ready_i held 0 for 5 cycles with valid_i=1 -> data_o and valid_o stay stable, exactly one beat is accepted, and no beat is lost or duplicated after ready_i rises.
REQ-024 Bias row 1 is written in the same cycle a beat with vec_idx=1 is accepted -> that beat uses the old row 1 value, and the next beat on row 1 uses the new value.
REQ-025 rst asserted asynchronously while valid_o=1 and ready_i=0 -> valid_o=0 and vec_idx_o=0 immediately; after release, the first beat uses row 0 with bias 0 (data_o=data_i).

Source files
------------

// File: rtl/params.svh
// Shared datapath geometry: lane width QW and lane count XW.
`ifndef PARAMS_SVH
`define PARAMS_SVH
`define QW 8
`define XW 4
`endif

// File: rtl/bias_add.sv
// Per-lane saturating bias add with a rotating bias table and a single output register.
// Optional macro BIAS_ADD_RELU_EN clamps negative lane results to zero.
`include "params.svh"

module bias_add #(
    parameter int unsigned BIAS_DEPTH = 4,
    localparam int unsigned IW = (BIAS_DEPTH > 1) ? $clog2(BIAS_DEPTH) : 1,
    localparam int unsigned NW = $clog2(BIAS_DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [`XW-1:0][`QW-1:0]       data_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    output logic [`XW-1:0][`QW-1:0]       data_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    input  logic [NW-1:0]                 cfg_num_vec,
    input  logic                          bias_wr_en,
    input  logic [IW-1:0]                 bias_wr_addr,
    input  logic [`XW-1:0][`QW-1:0]       bias_wr_data,
    output logic [IW-1:0]                 vec_idx_o
);

    logic [BIAS_DEPTH-1:0][`XW-1:0][`QW-1:0] bias_q;
    logic [`XW-1:0][`QW-1:0]                 bias_row;
    logic [`XW-1:0][`QW-1:0]                 data_q;
    logic [`XW-1:0][`QW-1:0]                 lane_res;
    logic signed [`QW:0]                     lane_sum [`XW];
    logic                                    valid_q;
    logic [IW-1:0]                           vec_idx_q;
    logic [IW-1:0]                           vec_idx_d;
    logic                                    accept;
    int unsigned                             eff_num;

    assign ready_o   = ~valid_q | ready_i;
    assign accept    = valid_i & ready_o;
    assign valid_o   = valid_q;
    assign data_o    = data_q;
    assign vec_idx_o = vec_idx_q;
    assign bias_row  = bias_q[vec_idx_q];

    always_comb begin
        eff_num = 32'(cfg_num_vec);
        if (eff_num == 0) eff_num = 1;
        if (eff_num > BIAS_DEPTH) eff_num = BIAS_DEPTH;
        // >= keeps the index in range if cfg_num_vec shrinks mid-stream
        if (32'(vec_idx_q) >= eff_num - 1) vec_idx_d = '0;
        else                                vec_idx_d = vec_idx_q + 1'b1;
    end

    always_comb begin
        lane_res = '0;
        for (int k = 0; k < `XW; k++) begin
            lane_sum[k] = $signed({data_i[k][`QW-1], data_i[k]})
                        + $signed({bias_row[k][`QW-1], bias_row[k]});
            if (lane_sum[k][`QW] != lane_sum[k][`QW-1]) begin
                lane_res[k] = lane_sum[k][`QW] ? {1'b1, {(`QW-1){1'b0}}}
                                               : {1'b0, {(`QW-1){1'b1}}};
            end else begin
                lane_res[k] = lane_sum[k][`QW-1:0];
            end
`ifdef BIAS_ADD_RELU_EN
            if (lane_res[k][`QW-1]) lane_res[k] = '0;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= 1'b0;
            data_q    <= '0;
            vec_idx_q <= '0;
        end else begin
            if (accept) begin
                valid_q   <= 1'b1;
                data_q    <= lane_res;
                vec_idx_q <= vec_idx_d;
            end else if (ready_i) begin
                valid_q <= 1'b0;
            end
        end
    end

    // The datapath reads bias_q before this edge updates it, giving read-before-write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bias_q <= '0;
        end else if (bias_wr_en && (32'(bias_wr_addr) < BIAS_DEPTH)) begin
            bias_q[bias_wr_addr] <= bias_wr_data;
        end
    end

endmodule
